// File: rtl/bit_rev_reorder.sv
// Bit-reversal reorder buffer: loads one frame of 2^LOG2N complex samples in natural
// order and streams them back out in bit-reversed order. Optional macro BIT_REV_NATURAL_EN.
module bit_rev_reorder #(
    parameter int LOG2N  = 6,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start,
`ifdef BIT_REV_NATURAL_EN
    input  logic              natural_mode,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [LOG2N-1:0]  out_index,
    output logic              busy,
    output logic              tc
);

    localparam int N = 1 << LOG2N;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [LOG2N-1:0]    r_wr_cnt;
    logic [LOG2N-1:0]    r_rd_cnt;
    logic [LOG2N-1:0]    w_rev;
    logic [LOG2N-1:0]    w_rd_addr;
    logic                w_last_wr;
    logic                w_last_rd;
    logic [2*DATA_W-1:0] r_mem [N];

    assign w_last_wr = &r_wr_cnt;
    assign w_last_rd = &r_rd_cnt;

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < LOG2N; i++) begin
            w_rev[i] = r_rd_cnt[LOG2N-1-i];
        end
    end

`ifdef BIT_REV_NATURAL_EN
    logic r_natural;

    // The ordering choice is frozen for the whole frame at the moment it is accepted.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_natural <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_natural <= natural_mode;
        end
    end

    assign w_rd_addr = r_natural ? r_rd_cnt : w_rev;
`else
    assign w_rd_addr = w_rev;
`endif

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  if (in_valid && w_last_wr) w_next = S_DRAIN;
            S_DRAIN: if (w_last_rd) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_wr_cnt <= '0;
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_wr_cnt <= r_wr_cnt + LOG2N'(1);
                        if (w_last_wr) r_rd_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    r_rd_cnt <= r_rd_cnt + LOG2N'(1);
                end
                default: ;
            endcase
        end
    end

    // Sample storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge Clk) begin
        if (r_state == S_LOAD && in_valid) begin
            r_mem[r_wr_cnt] <= {in_re, in_im};
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_index <= '0;
            busy      <= 1'b0;
            tc        <= 1'b0;
        end else begin
            out_valid <= (r_state == S_DRAIN);
            tc        <= (r_state == S_DRAIN) && w_last_rd;
            busy      <= (w_next != S_IDLE);
            if (r_state == S_DRAIN) begin
                out_index         <= r_rd_cnt;
                {out_re, out_im}  <= r_mem[w_rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_bit_rev_reorder.sv
// Directed testbench for bit_rev_reorder at LOG2N=3, DATA_W=16; expected orderings are
// a hand-written bit-reverse table.
module tb_bit_rev_reorder;

    logic        Clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        out_valid;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic [2:0]  out_index;
    logic        busy;
    logic        tc;
`ifdef BIT_REV_NATURAL_EN
    logic        natural_mode;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lastDrive = 0;
    int rev8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic [15:0] capRe [$];
    logic [15:0] capIm [$];
    logic [2:0]  capIdx [$];
    logic        capTc [$];
    int          capCyc [$];

    bit_rev_reorder #(.LOG2N(3), .DATA_W(16)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .start     (start),
`ifdef BIT_REV_NATURAL_EN
        .natural_mode(natural_mode),
`endif
        .in_valid  (in_valid),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_index (out_index),
        .busy      (busy),
        .tc        (tc)
    );

    always #5 Clk = ~Clk;

    // Records every valid output beat together with the clock count it appeared on.
    always @(posedge Clk) begin
        #1;
        cyc++;
        if (out_valid) begin
            capRe.push_back(out_re);
            capIm.push_back(out_im);
            capIdx.push_back(out_index);
            capTc.push_back(tc);
            capCyc.push_back(cyc);
        end
    end

    task automatic clear_capture();
        capRe.delete();
        capIm.delete();
        capIdx.delete();
        capTc.delete();
        capCyc.delete();
    endtask

    // Pulses start, then feeds 8 samples re=base+k, im=100+k; optional gaps and stray start pulses.
    task automatic drive_frame(input logic [15:0] base, input bit gaps, input bit pulses);
        start = 1'b1;
        @(negedge Clk);
        for (int k = 0; k < 8; k++) begin
            start    = pulses && (k == 3);
            in_valid = 1'b1;
            in_re    = 16'(base + k);
            in_im    = 16'(100 + k);
            lastDrive = cyc;
            @(negedge Clk);
            if (gaps) begin
                start    = 1'b0;
                in_valid = 1'b0;
                in_re    = 16'hDEAD;
                @(negedge Clk);
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (pulses) begin
            repeat (2) @(negedge Clk);
            start = 1'b1;
            @(negedge Clk);
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_re = 16'h0;
        in_im = 16'h0;
        repeat (2) @(negedge Clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_re !== 16'h0) begin bad++; $display("[TB] FAIL reset_out_re got=%h want=0", out_re); end
        total++; if (out_im !== 16'h0) begin bad++; $display("[TB] FAIL reset_out_im got=%h want=0", out_im); end
        total++; if (out_index !== 3'd0) begin bad++; $display("[TB] FAIL reset_out_index got=%0d want=0", out_index); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (tc !== 1'b0) begin bad++; $display("[TB] FAIL reset_tc got=%b want=0", tc); end
        reset = 1'b0;
        // Samples offered while idle must not start anything.
        in_valid = 1'b1;
        in_re = 16'h5555;
        repeat (3) @(negedge Clk);
        in_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_ignore_busy got=%b want=0", busy); end
    endtask

    task automatic test_basic();
        clear_capture();
        drive_frame(16'd0, 1'b0, 1'b0);
        for (int t = 0; t < 60 && capRe.size() < 8; t++) @(negedge Clk);
        repeat (3) @(negedge Clk);
        total++; if (capRe.size() !== 8) begin bad++; $display("[TB] FAIL basic_count got=%0d want=8", capRe.size()); end
        for (int i = 0; i < 8 && i < capRe.size(); i++) begin
            total++; if (capRe[i] !== 16'(rev8[i])) begin bad++; $display("[TB] FAIL basic_re[%0d] got=%0d want=%0d", i, capRe[i], rev8[i]); end
            total++; if (capIm[i] !== 16'(100 + rev8[i])) begin bad++; $display("[TB] FAIL basic_im[%0d] got=%0d want=%0d", i, capIm[i], 100 + rev8[i]); end
            total++; if (capIdx[i] !== 3'(i)) begin bad++; $display("[TB] FAIL basic_index[%0d] got=%0d want=%0d", i, capIdx[i], i); end
            total++; if (capTc[i] !== (i == 7)) begin bad++; $display("[TB] FAIL basic_tc[%0d] got=%b want=%b", i, capTc[i], i == 7); end
            total++; if (capCyc[i] !== capCyc[0] + i) begin bad++; $display("[TB] FAIL basic_contig[%0d] got=%0d want=%0d", i, capCyc[i], capCyc[0] + i); end
        end
        if (capRe.size() > 0) begin
            total++; if (capCyc[0] !== lastDrive + 2) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=%0d", capCyc[0] - lastDrive, 2); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_gaps();
        clear_capture();
        drive_frame(16'd0, 1'b1, 1'b1);
        for (int t = 0; t < 60 && capRe.size() < 8; t++) @(negedge Clk);
        repeat (20) @(negedge Clk);
        total++; if (capRe.size() !== 8) begin bad++; $display("[TB] FAIL gaps_count got=%0d want=8", capRe.size()); end
        for (int i = 0; i < 8 && i < capRe.size(); i++) begin
            total++; if (capRe[i] !== 16'(rev8[i])) begin bad++; $display("[TB] FAIL gaps_re[%0d] got=%0d want=%0d", i, capRe[i], rev8[i]); end
            total++; if (capIdx[i] !== 3'(i)) begin bad++; $display("[TB] FAIL gaps_index[%0d] got=%0d want=%0d", i, capIdx[i], i); end
            total++; if (capTc[i] !== (i == 7)) begin bad++; $display("[TB] FAIL gaps_tc[%0d] got=%b want=%b", i, capTc[i], i == 7); end
        end
        if (capRe.size() > 0) begin
            total++; if (capCyc[0] !== lastDrive + 2) begin bad++; $display("[TB] FAIL gaps_latency got=%0d want=%0d", capCyc[0] - lastDrive, 2); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL gaps_stray_start_busy got=%b want=0", busy); end
    endtask

    task automatic test_drain_inputs();
        clear_capture();
        drive_frame(16'd32, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_re = 16'hFFFF;
        in_im = 16'hFFFF;
        repeat (12) @(negedge Clk);
        in_valid = 1'b0;
        for (int t = 0; t < 60 && capRe.size() < 8; t++) @(negedge Clk);
        repeat (3) @(negedge Clk);
        total++; if (capRe.size() !== 8) begin bad++; $display("[TB] FAIL drain_count got=%0d want=8", capRe.size()); end
        for (int i = 0; i < 8 && i < capRe.size(); i++) begin
            total++; if (capRe[i] !== 16'(32 + rev8[i])) begin bad++; $display("[TB] FAIL drain_re[%0d] got=%0d want=%0d", i, capRe[i], 32 + rev8[i]); end
            total++; if (capIm[i] !== 16'(100 + rev8[i])) begin bad++; $display("[TB] FAIL drain_im[%0d] got=%0d want=%0d", i, capIm[i], 100 + rev8[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_capture();
        start = 1'b1;
        @(negedge Clk);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_re = 16'(k);
            in_im = 16'(100 + k);
            @(negedge Clk);
        end
        in_valid = 1'b0;
        repeat (9) @(negedge Clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle_gap_busy got=%b want=0", busy); end
        @(negedge Clk);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_restart_busy got=%b want=1", busy); end
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_re = 16'(16 + k);
            in_im = 16'(100 + k);
            @(negedge Clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        for (int t = 0; t < 60 && capRe.size() < 16; t++) @(negedge Clk);
        repeat (3) @(negedge Clk);
        total++; if (capRe.size() !== 16) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=16", capRe.size()); end
        for (int i = 0; i < 16 && i < capRe.size(); i++) begin
            total++; if (capRe[i] !== 16'((i / 8) * 16 + rev8[i % 8])) begin bad++; $display("[TB] FAIL b2b_re[%0d] got=%0d want=%0d", i, capRe[i], (i / 8) * 16 + rev8[i % 8]); end
            total++; if (capIdx[i] !== 3'(i % 8)) begin bad++; $display("[TB] FAIL b2b_index[%0d] got=%0d want=%0d", i, capIdx[i], i % 8); end
        end
        if (capRe.size() > 8) begin
            total++; if (capCyc[8] - capCyc[0] !== 18) begin bad++; $display("[TB] FAIL b2b_period got=%0d want=18", capCyc[8] - capCyc[0]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_re = 16'(64 + k);
            in_im = 16'(100 + k);
            @(negedge Clk);
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
        total++; if (out_re !== 16'h0) begin bad++; $display("[TB] FAIL midrst_out_re got=%h want=0", out_re); end
        total++; if (out_im !== 16'h0) begin bad++; $display("[TB] FAIL midrst_out_im got=%h want=0", out_im); end
        total++; if (out_index !== 3'd0) begin bad++; $display("[TB] FAIL midrst_out_index got=%0d want=0", out_index); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_out_valid got=%b want=0", out_valid); end
        @(negedge Clk);
        reset = 1'b0;
        clear_capture();
        repeat (2) @(negedge Clk);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_wait_busy got=%b want=0", busy); end
        drive_frame(16'd40, 1'b0, 1'b0);
        for (int t = 0; t < 60 && capRe.size() < 8; t++) @(negedge Clk);
        repeat (5) @(negedge Clk);
        total++; if (capRe.size() !== 8) begin bad++; $display("[TB] FAIL midrst_count got=%0d want=8", capRe.size()); end
        for (int i = 0; i < 8 && i < capRe.size(); i++) begin
            total++; if (capRe[i] !== 16'(40 + rev8[i])) begin bad++; $display("[TB] FAIL midrst_re[%0d] got=%0d want=%0d", i, capRe[i], 40 + rev8[i]); end
            total++; if (capIdx[i] !== 3'(i)) begin bad++; $display("[TB] FAIL midrst_index[%0d] got=%0d want=%0d", i, capIdx[i], i); end
        end
    endtask

`ifdef BIT_REV_NATURAL_EN
    task automatic test_natural();
        clear_capture();
        natural_mode = 1'b1;
        drive_frame(16'd0, 1'b0, 1'b0);
        natural_mode = 1'b0;
        for (int t = 0; t < 60 && capRe.size() < 8; t++) @(negedge Clk);
        repeat (3) @(negedge Clk);
        total++; if (capRe.size() !== 8) begin bad++; $display("[TB] FAIL natural_count got=%0d want=8", capRe.size()); end
        for (int i = 0; i < 8 && i < capRe.size(); i++) begin
            total++; if (capRe[i] !== 16'(i)) begin bad++; $display("[TB] FAIL natural_re[%0d] got=%0d want=%0d", i, capRe[i], i); end
            total++; if (capTc[i] !== (i == 7)) begin bad++; $display("[TB] FAIL natural_tc[%0d] got=%b want=%b", i, capTc[i], i == 7); end
        end
    endtask
`endif

    initial begin
`ifdef BIT_REV_NATURAL_EN
        natural_mode = 1'b0;
`endif
        test_reset();
        test_basic();
        test_gaps();
        test_drain_inputs();
        test_back_to_back();
        test_reset_mid_load();
`ifdef BIT_REV_NATURAL_EN
        test_natural();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
